// File: rtl/mult_arb_2ch.sv
// ---------------------------------------------------------------------------
// mult_arb_2ch
//
// Sequential front end for a 4x4 unsigned array multiplier. Two requesters
// share the one multiplier; each accepted operand pair produces a single
// 8-bit product on the response channel, tagged with the requester ID.
// Only one transaction is ever in flight.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Requesters hold valid and operands stable until ready;
// the consumer sees rsp_valid held with stable rsp_prod/rsp_id until
// rsp_ready.
//
// Parameters:
//   MUL_CYCLES  settle cycles spent in MUL before capture (legal 1..4)
//
// Ports:
//   clk                       rising-edge clock
//   rst                       asynchronous active-high reset
//   req0_valid/a/b, req0_ready requester 0 operand channel
//   req1_valid/a/b, req1_ready requester 1 operand channel
//   rsp_valid, rsp_ready       response handshake
//   rsp_prod                   registered product a*b
//   rsp_id                     requester that issued the product
//
// Build option:
//   MULT_ARB_FIXED_PRIO_EN  when defined, req0 always wins a tie and there
//                           is no round-robin pointer (req1 can starve).
//                           Undefined: round-robin arbitration.
// ---------------------------------------------------------------------------
module mult_arb_2ch #(
   parameter int MUL_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       req1_ready,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_prod,
   output logic       rsp_id
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // MUL counts down from this value; capture happens when the count is zero.
   localparam logic [1:0] CNT_LOAD = 2'(MUL_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] op_a_q, op_a_d;
   logic [3:0] op_b_q, op_b_d;
   logic       id_q, id_d;
   logic [1:0] cnt_q, cnt_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_prod_q, rsp_prod_d;
   logic       rsp_id_q, rsp_id_d;

   logic       grant0;
   logic       grant1;
   logic [7:0] mult_out;

`ifdef MULT_ARB_FIXED_PRIO_EN
   // Fixed priority: req0 wins every tie.
   assign grant0 = req0_valid;
   assign grant1 = req1_valid & ~req0_valid;
`else
   // Round-robin: ptr_q names the preferred channel when both are valid.
   logic ptr_q, ptr_d;

   assign grant0 = req0_valid & (~req1_valid | ~ptr_q);
   assign grant1 = req1_valid & (~req0_valid | ptr_q);
`endif

   // Grants are mutually exclusive, so at most one ready is high. Ready is
   // also forced low while reset is asserted.
   assign req0_ready = ~rst & (state_q == ST_IDLE) & grant0;
   assign req1_ready = ~rst & (state_q == ST_IDLE) & grant1;

   // 4x4 array multiplier: sum of shifted partial products of the
   // registered operands.
   always_comb begin
      mult_out = 8'd0;
      for (int i = 0; i < 4; i++) begin
         if (op_b_q[i]) begin
            mult_out = mult_out + ({4'd0, op_a_q} << i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_prod_d  = rsp_prod_q;
      rsp_id_d    = rsp_id_q;
`ifndef MULT_ARB_FIXED_PRIO_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant0 | grant1) begin
               op_a_d  = grant1 ? req1_a : req0_a;
               op_b_d  = grant1 ? req1_b : req0_b;
               id_d    = grant1;
               cnt_d   = CNT_LOAD;
`ifndef MULT_ARB_FIXED_PRIO_EN
               // Prefer the channel that was not just served.
               ptr_d   = grant0;
`endif
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               rsp_prod_d  = mult_out;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_a_q      <= 4'd0;
         op_b_q      <= 4'd0;
         id_q        <= 1'b0;
         cnt_q       <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_prod_q  <= 8'd0;
         rsp_id_q    <= 1'b0;
`ifndef MULT_ARB_FIXED_PRIO_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_prod_q  <= rsp_prod_d;
         rsp_id_q    <= rsp_id_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_prod  = rsp_prod_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_arb_2ch.sv
// ---------------------------------------------------------------------------
// tb_mult_arb_2ch
//
// Two instances of mult_arb_2ch (MUL_CYCLES=1 and MUL_CYCLES=4), each with
// its own signal set selected by index d. Directed vectors and sequences
// cover reset, single requests, arbitration, backpressure and aborts; a
// random phase compares each instance against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mult_arb_2ch;

   logic clk;

   logic [1:0]      rst;
   logic [1:0]      r0_valid, r1_valid, r0_ready, r1_ready;
   logic [1:0][3:0] r0_a, r0_b, r1_a, r1_b;
   logic [1:0]      rsp_valid, rsp_ready, rsp_id;
   logic [1:0][7:0] rsp_prod;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       ch;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] prod;
   } vec_t;

   vec_t vecs [8];

   // Scoreboard: {id, product} of accepted requests awaiting response.
   logic [8:0] exp_q [$];

   mult_arb_2ch #(.MUL_CYCLES(1)) u_dut_fast (
      .clk        (clk),
      .rst        (rst[0]),
      .req0_valid (r0_valid[0]),
      .req0_a     (r0_a[0]),
      .req0_b     (r0_b[0]),
      .req0_ready (r0_ready[0]),
      .req1_valid (r1_valid[0]),
      .req1_a     (r1_a[0]),
      .req1_b     (r1_b[0]),
      .req1_ready (r1_ready[0]),
      .rsp_valid  (rsp_valid[0]),
      .rsp_ready  (rsp_ready[0]),
      .rsp_prod   (rsp_prod[0]),
      .rsp_id     (rsp_id[0])
   );

   mult_arb_2ch #(.MUL_CYCLES(4)) u_dut_slow (
      .clk        (clk),
      .rst        (rst[1]),
      .req0_valid (r0_valid[1]),
      .req0_a     (r0_a[1]),
      .req0_b     (r0_b[1]),
      .req0_ready (r0_ready[1]),
      .req1_valid (r1_valid[1]),
      .req1_a     (r1_a[1]),
      .req1_b     (r1_b[1]),
      .req1_ready (r1_ready[1]),
      .rsp_valid  (rsp_valid[1]),
      .rsp_ready  (rsp_ready[1]),
      .rsp_prod   (rsp_prod[1]),
      .rsp_id     (rsp_id[1])
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mc_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   task automatic check(input string name, input int d,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs(input int d);
      r0_valid[d] = 1'b0; r0_a[d] = 4'd0; r0_b[d] = 4'd0;
      r1_valid[d] = 1'b0; r1_a[d] = 4'd0; r1_b[d] = 4'd0;
      rsp_ready[d] = 1'b0;
   endtask

   task automatic do_reset(input int d);
      @(posedge clk); #1;
      idle_inputs(d);
      rst[d] = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      @(posedge clk); #1;
      r0_valid[d] = 1'b0;
      r1_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      repeat (mc_of(d) + 3) @(posedge clk);
      #1 rsp_ready[d] = 1'b0;
   endtask

   task automatic wait_rsp(input int d, input int max, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max && !ok; k++) begin
         @(negedge clk);
         if (rsp_valid[d]) ok = 1'b1;
      end
   endtask

   // ---------------- directed sequences ----------------
   task automatic single_req(input int d, input vec_t v);
      int n;
      n = mc_of(d);
      @(posedge clk); #1;
      rsp_ready[d] = 1'b1;
      if (v.ch == 1'b0) begin
         r0_valid[d] = 1'b1; r0_a[d] = v.a; r0_b[d] = v.b;
      end else begin
         r1_valid[d] = 1'b1; r1_a[d] = v.a; r1_b[d] = v.b;
      end
      @(negedge clk);
      check("req_ready", d, v.ch ? r1_ready[d] : r0_ready[d], 1);
      check("other_ready_low", d, v.ch ? r0_ready[d] : r1_ready[d], 0);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("mul_rsp_low", d, rsp_valid[d], 0);
         check("mul_ready_low", d, r0_ready[d] | r1_ready[d], 0);
      end
      @(negedge clk);
      check("rsp_valid", d, rsp_valid[d], 1);
      check("rsp_prod", d, rsp_prod[d], v.prod);
      check("rsp_id", d, rsp_id[d], v.ch);
      check("hold_ready_low", d, r0_ready[d] | r1_ready[d], 0);
      @(posedge clk); #1;
      r0_valid[d] = 1'b0;
      r1_valid[d] = 1'b0;
      rsp_ready[d] = 1'b0;
      @(negedge clk);
      check("rsp_cleared", d, rsp_valid[d], 0);
   endtask

   task automatic arb_test(input int d);
      int n, got, cyc, last_hs;
      logic exp_id;
      bit ok;
      n = mc_of(d);
      do_reset(d);
      @(posedge clk); #1;
      r0_valid[d] = 1'b1; r0_a[d] = 4'd15; r0_b[d] = 4'd15;
      r1_valid[d] = 1'b1; r1_a[d] = 4'd9;  r1_b[d] = 4'd7;
      rsp_ready[d] = 1'b1;
      got = 0; cyc = 0; last_hs = -1;
      while (got < 4 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         check("ready_exclusive", d, r0_ready[d] & r1_ready[d], 0);
         if (r0_ready[d] | r1_ready[d]) begin
            if (last_hs >= 0) check("hs_spacing", d, cyc - last_hs, n + 2);
            last_hs = cyc;
         end
         if (rsp_valid[d]) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = got[0];
`endif
            check("arb_id", d, rsp_id[d], exp_id);
            check("arb_prod", d, rsp_prod[d], exp_id ? 8'h3F : 8'hE1);
            got++;
         end
      end
      check("arb_count", d, got, 4);
      // req0 withdraws: req1 must now be served.
      @(posedge clk); #1;
      r0_valid[d] = 1'b0;
      wait_rsp(d, 3 * (n + 2), ok);
      check("after_drop_seen", d, ok, 1);
      check("after_drop_id", d, rsp_id[d], 1);
      check("after_drop_prod", d, rsp_prod[d], 8'h3F);
      drain(d);
   endtask

   task automatic backpressure_test(input int d);
      int n;
      bit ok;
      n = mc_of(d);
      do_reset(d);
      @(posedge clk); #1;
      r1_valid[d] = 1'b1; r1_a[d] = 4'd9; r1_b[d] = 4'd7;
      rsp_ready[d] = 1'b0;
      wait_rsp(d, n + 5, ok);
      check("bp_rsp_seen", d, ok, 1);
      @(posedge clk); #1;
      r1_valid[d] = 1'b0;
      r0_valid[d] = 1'b1; r0_a[d] = 4'd2; r0_b[d] = 4'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", d, rsp_valid[d], 1);
         check("bp_prod", d, rsp_prod[d], 8'h3F);
         check("bp_id", d, rsp_id[d], 1);
         check("bp_ready_low", d, r0_ready[d] | r1_ready[d], 0);
      end
      @(posedge clk); #1;
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      check("bp_release_valid", d, rsp_valid[d], 1);
      check("bp_release_ready_low", d, r0_ready[d], 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_delivered_once", d, rsp_valid[d], 0);
      check("bp_next_accept", d, r0_ready[d], 1);
      @(posedge clk); #1;
      r0_valid[d] = 1'b0;
      wait_rsp(d, n + 3, ok);
      check("bp_next_seen", d, ok, 1);
      check("bp_next_prod", d, rsp_prod[d], 8'h06);
      check("bp_next_id", d, rsp_id[d], 0);
      drain(d);
   endtask

   task automatic reset_hold_test(input int d);
      int n;
      bit ok;
      n = mc_of(d);
      do_reset(d);
      @(posedge clk); #1;
      r1_valid[d] = 1'b1; r1_a[d] = 4'd9; r1_b[d] = 4'd7;
      wait_rsp(d, n + 5, ok);
      check("rh_rsp_seen", d, ok, 1);
      check("rh_prod_before", d, rsp_prod[d], 8'h3F);
      r0_valid[d] = 1'b1; r0_a[d] = 4'd4; r0_b[d] = 4'd4;
      #2 rst[d] = 1'b1;
      #1;
      check("rh_valid", d, rsp_valid[d], 0);
      check("rh_prod", d, rsp_prod[d], 8'h00);
      check("rh_id", d, rsp_id[d], 0);
      check("rh_ready0", d, r0_ready[d], 0);
      check("rh_ready1", d, r1_ready[d], 0);
      @(negedge clk);
      check("rh_ready_held", d, r0_ready[d] | r1_ready[d], 0);
      idle_inputs(d);
      #1 rst[d] = 1'b0;
   endtask

   task automatic abort_test(input int d);
      int n;
      bit ok;
      n = mc_of(d);
      do_reset(d);
      @(posedge clk); #1;
      r0_valid[d] = 1'b1; r0_a[d] = 4'd5; r0_b[d] = 4'd5;
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      check("ab_accept", d, r0_ready[d], 1);
      @(posedge clk); #1;
      r0_valid[d] = 1'b0;
      @(negedge clk);
      #1 rst[d] = 1'b1;
      #2 rst[d] = 1'b0;
      for (int k = 0; k < n + 4; k++) begin
         @(negedge clk);
         check("ab_no_rsp", d, rsp_valid[d], 0);
      end
      @(posedge clk); #1;
      r0_valid[d] = 1'b1; r0_a[d] = 4'd10; r0_b[d] = 4'd12;
      r1_valid[d] = 1'b1; r1_a[d] = 4'd3;  r1_b[d] = 4'd3;
      @(negedge clk);
      check("ab_req0_first", d, r0_ready[d], 1);
      check("ab_req1_wait", d, r1_ready[d], 0);
      @(posedge clk); #1;
      r0_valid[d] = 1'b0;
      r1_valid[d] = 1'b0;
      wait_rsp(d, n + 3, ok);
      check("ab_next_seen", d, ok, 1);
      check("ab_next_prod", d, rsp_prod[d], 8'h78);
      check("ab_next_id", d, rsp_id[d], 0);
      drain(d);
   endtask

   // ---------------- random phase with reference model ----------------
   task automatic random_test(input int d, input int ncyc);
      int   n, wait_cnt;
      bit   busy, holding, pref, hs0, hs1, exp_r0, exp_r1;
      logic [7:0] p;
      n = mc_of(d);
      do_reset(d);
      busy = 0; holding = 0; pref = 0; wait_cnt = 0; hs0 = 0; hs1 = 0;
      exp_q.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         if (hs0 || !r0_valid[d]) begin
            r0_valid[d] = ($urandom_range(0, 3) != 0);
            r0_a[d] = 4'($urandom_range(0, 15));
            r0_b[d] = 4'($urandom_range(0, 15));
         end else if ($urandom_range(0, 15) == 0) begin
            r0_valid[d] = 1'b0;
         end
         if (hs1 || !r1_valid[d]) begin
            r1_valid[d] = ($urandom_range(0, 3) != 0);
            r1_a[d] = 4'($urandom_range(0, 15));
            r1_b[d] = 4'($urandom_range(0, 15));
         end else if ($urandom_range(0, 15) == 0) begin
            r1_valid[d] = 1'b0;
         end
         rsp_ready[d] = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         exp_r0 = 0;
         exp_r1 = 0;
         if (!busy) begin
            if (r0_valid[d] && r1_valid[d]) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
               exp_r0 = 1;
`else
               if (pref) exp_r1 = 1;
               else      exp_r0 = 1;
`endif
            end else begin
               exp_r0 = r0_valid[d];
               exp_r1 = r1_valid[d];
            end
         end
         check("rnd_ready0", d, r0_ready[d], exp_r0);
         check("rnd_ready1", d, r1_ready[d], exp_r1);
         check("rnd_rsp_valid", d, rsp_valid[d], holding);
         if (holding && exp_q.size() > 0) begin
            check("rnd_prod", d, rsp_prod[d], exp_q[0][7:0]);
            check("rnd_id", d, rsp_id[d], exp_q[0][8]);
         end
         hs0 = exp_r0;
         hs1 = exp_r1;
         if (holding && rsp_ready[d]) begin
            void'(exp_q.pop_front());
            holding = 0;
            busy = 0;
         end else if (busy && !holding) begin
            wait_cnt--;
            if (wait_cnt == 0) holding = 1;
         end
         if (hs0 || hs1) begin
            if (hs1) p = 8'(r1_a[d]) * 8'(r1_b[d]);
            else     p = 8'(r0_a[d]) * 8'(r0_b[d]);
            exp_q.push_back({hs1, p});
            busy = 1;
            wait_cnt = n;
            pref = hs0;
         end
      end
      drain(d);
   endtask

   // ---------------- main ----------------
   initial begin
      vecs[0] = '{1'b0, 4'd3,  4'd5,  8'h0F};
      vecs[1] = '{1'b1, 4'd9,  4'd7,  8'h3F};
      vecs[2] = '{1'b0, 4'd15, 4'd15, 8'hE1};
      vecs[3] = '{1'b1, 4'd0,  4'd13, 8'h00};
      vecs[4] = '{1'b0, 4'd1,  4'd1,  8'h01};
      vecs[5] = '{1'b1, 4'd10, 4'd12, 8'h78};
      vecs[6] = '{1'b0, 4'd15, 4'd0,  8'h00};
      vecs[7] = '{1'b1, 4'd8,  4'd8,  8'h40};

      rst = 2'b11;
      for (int d = 0; d < 2; d++) begin
         idle_inputs(d);
         r0_valid[d] = 1'b1;
         r1_valid[d] = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_rsp_valid", d, rsp_valid[d], 0);
         check("reset_rsp_prod", d, rsp_prod[d], 8'h00);
         check("reset_rsp_id", d, rsp_id[d], 0);
         check("reset_ready", d, r0_ready[d] | r1_ready[d], 0);
         idle_inputs(d);
      end
      @(posedge clk); #1;
      rst = 2'b00;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("idle_no_req_ready", d, r0_ready[d] | r1_ready[d], 0);
         check("idle_rsp_low", d, rsp_valid[d], 0);
      end

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) single_req(d, vecs[i]);
         arb_test(d);
         backpressure_test(d);
         reset_hold_test(d);
         abort_test(d);
         random_test(d, 1500);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_arb_2ch.md
# mult_arb_2ch

Sequential front end for the combinational 4x4 array multiplier (`ArrMult_4bit`). It shares the one multiplier between two requesters through valid/ready handshakes and registers the operands and the product. It returns each 8-bit product on a single response channel, tagged with the requester ID. It sits between the lab's operand sources and the result consumer.

## Interface
- `MUL_CYCLES`, default 1: settle cycles spent in MUL before the product is captured; legal range 1..4.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_a`, `req0_b`  in  4 each  requester 0 operands, unsigned.
- `req0_ready`  out  1  requester 0 operands accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same roles for requester 1.
- `rsp_valid`  out  1  product available.
- `rsp_ready`  in  1  consumer accepts product.
- `rsp_prod`  out  8  registered product, a*b.
- `rsp_id`  out  1  requester that issued the product.

## Operation
- FSM states are IDLE, MUL and HOLD.
- Internal registers:
  - operand regs `op_a`/`op_b` (4b each) drive the multiplier;
  - `id_r`;
  - `cnt` (2b);
  - priority pointer `ptr` (1b; 0 means req0 is preferred).
- IDLE:
  - Grant rule: only one valid → grant it; both valid → grant `ptr`.
  - `reqX_ready` = (state==IDLE) & grantX. It is combinational and is never high for both requesters.
  - On the handshake: latch operands and ID, load `cnt`=MUL_CYCLES-1, set `ptr` to the non-granted channel, go to MUL.
- MUL:
  - If `cnt`!=0, decrement.
  - If `cnt`==0, capture the multiplier output into `rsp_prod`, set `rsp_id`=`id_r` and `rsp_valid`=1, go to HOLD.
- HOLD:
  - `rsp_valid`=1; `rsp_prod` and `rsp_id` stay stable.
  - When `rsp_ready`=1, clear `rsp_valid` and go to IDLE.
- Both ready outputs are 0 in MUL and HOLD, so there is never more than one transaction in flight.
- Requesters hold `valid` and operands stable until `ready`. Operands are sampled only at the handshake edge.
- Arithmetic: unsigned 4x4 to 8 bits, no overflow. Maximum is 15*15=225 (0xE1).
- Boundary cases:
  - `rsp_ready` high in IDLE or MUL is ignored.
  - A requester dropping `valid` while not granted is legal and has no effect.
  - `ptr` changes only on a request handshake.
  - Reset asserted mid-transaction aborts it. No response is issued and the in-flight operands are discarded.

## Timing
- Reset values: state=IDLE, `rsp_valid`=0, `rsp_prod`=0x00, `rsp_id`=0, `ptr`=0, `cnt`=0. Both ready outputs are 0 until the first IDLE cycle with a valid request.
- Request handshake at edge N → `rsp_valid` rises after edge N+MUL_CYCLES.
- Response handshake at edge M → earliest next request handshake is at edge M+1.
- Throughput with `rsp_ready` held at 1: one product every MUL_CYCLES+2 cycles (every 3 cycles at the default).
- `rst` acts immediately (asynchronously). Deassertion is synchronised externally.

## Configuration
- `MULT_ARB_FIXED_PRIO_EN`
  - Defined: when both requesters are valid, req0 always wins; `ptr` is not implemented and req1 can starve.
  - Undefined (default): round-robin via `ptr` as described in Operation.

## Test plan
- Reset: assert `rst` mid-HOLD → `rsp_valid`=0, `rsp_prod`=0x00, `rsp_id`=0, both ready outputs 0 while `rst` is high.
- Single request: req0 a=3 b=5, `rsp_ready`=1, MUL_CYCLES=1 → accepted at edge N; `rsp_prod`=0x0F, `rsp_id`=0 valid after edge N+1; req0 is not re-accepted before edge N+3.
- Round-robin: req0 (15,15) and req1 (9,7) both held valid → responses alternate 0xE1 (id0), 0x3F (id1), 0xE1, 0x3F; ready never high for both in the same cycle.
- Backpressure: `rsp_ready`=0 for 5 cycles in HOLD → `rsp_valid`, `rsp_prod` and `rsp_id` are stable; both ready outputs stay 0; a product is delivered once when `rsp_ready`=1.
- Abort: pulse `rst` during MUL with MUL_CYCLES=4 → no response; state IDLE and `ptr`=0; the next request completes normally (a=10, b=12 → 0x78).
- `MULT_ARB_FIXED_PRIO_EN` defined: both requesters continuously valid → four consecutive responses all `rsp_id`=0; req1 is granted only after req0 drops `valid`.
